// File: rtl/pwm_ramp_if.sv
// ============================================================================
// Module : pwm_ramp_if
// Brief  : Target/load request and value/busy/done status bundle for pwm_ramp.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface pwm_ramp_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] target;
   logic             load;
   logic [WIDTH-1:0] value;
   logic             busy;
   logic             done;

   modport master (
      output target,
      output load,
      input  value,
      input  busy,
      input  done
   );

   modport slave (
      input  target,
      input  load,
      output value,
      output busy,
      output done
   );
endinterface

`default_nettype wire

// File: rtl/pwm_ramp.sv
// ============================================================================
// Module : pwm_ramp
// Brief  : Ramps a PWM duty value toward a loaded target, one step per N periods.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pwm_ramp #(
   parameter int WIDTH            = 4,
   parameter int PERIODS_PER_STEP = 4,
   parameter int STEP             = 1
) (
   input  wire logic   clock,
   input  wire logic   reset_n,
   pwm_ramp_if.slave   bus
);

   localparam int               c_div_w    = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(PERIODS_PER_STEP - 1);
   localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
   localparam logic [WIDTH-1:0]   c_step     = WIDTH'(STEP);
   localparam logic [WIDTH-1:0]   c_one      = WIDTH'(1);
   localparam logic [WIDTH-1:0]   c_phase_end = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_UP   = 2'd1,
      S_DOWN = 2'd2
   } state_t;

   state_t               r_state;
   logic [WIDTH-1:0]     r_phase;
   logic [c_div_w-1:0]   r_divider;
   logic [WIDTH-1:0]     r_target;
   logic [WIDTH-1:0]     r_value;
   logic                 r_done;

   logic                 w_period_tick;
   logic                 w_step_tick;
   logic [WIDTH-1:0]     w_up_gap;
   logic [WIDTH-1:0]     w_dn_gap;

   // Value updates land on the edge that wraps phase, so each new duty
   // starts cleanly at the beginning of a PWM period.
   assign w_period_tick = (r_phase == c_phase_end);
   assign w_step_tick   = w_period_tick && (r_divider == c_div_last);
   assign w_up_gap      = r_target - r_value;
   assign w_dn_gap      = r_value - r_target;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_phase <= '0;
      end else begin
         r_phase <= r_phase + c_one;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_divider <= '0;
         r_target  <= '0;
         r_value   <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.load) begin
            // A load restarts the step cadence and overrides any coincident step.
            r_target  <= bus.target;
            r_divider <= '0;
            if (bus.target > r_value) begin
               r_state <= S_UP;
            end else if (bus.target < r_value) begin
               r_state <= S_DOWN;
            end else begin
               r_state <= S_IDLE;
            end
         end else begin
            if (w_period_tick) begin
               r_divider <= (r_divider == c_div_last) ? '0 : r_divider + c_div_one;
            end
            if (w_step_tick) begin
               case (r_state)
                  S_UP: begin
                     if (w_up_gap <= c_step) begin
                        r_value <= r_target;
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                     end else begin
                        r_value <= r_value + c_step;
                     end
                  end
                  S_DOWN: begin
                     if (w_dn_gap <= c_step) begin
                        r_value <= r_target;
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                     end else begin
                        r_value <= r_value - c_step;
                     end
                  end
                  S_IDLE: begin
                     r_value <= r_value;
                  end
                  default: begin
                     r_state <= S_IDLE;
                  end
               endcase
            end
         end
      end
   end

   assign bus.value = r_value;
   assign bus.done  = r_done;
   assign bus.busy  = (r_state == S_UP) || (r_state == S_DOWN);

endmodule

`default_nettype wire

// File: doc/pwm_ramp.md
PWM_RAMP -- requirements
Module: pwm_ramp

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of the duty value; equals the WIDTH of the downstream pwm stage.
REQ-002 SHALL have parameter PERIODS_PER_STEP, default 4: number of PWM periods (2^WIDTH clocks each) between duty steps; legal range >=1.
REQ-003 SHALL have parameter STEP, default 1: duty increment per step; legal range 1..2^WIDTH-1.
REQ-004 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port target  input  WIDTH  requested final duty value; sampled only when load=1.
REQ-007 SHALL have port load  input  1  one-clock strobe that captures target and starts or redirects the ramp.
REQ-008 SHALL have port value  output  WIDTH  current duty value, registered; drives pwm.value.
REQ-009 SHALL have port busy  output  1  high while a ramp is in progress (state UP or DOWN).
REQ-010 SHALL have port done  output  1  one-clock pulse when value reaches the target.

Function
REQ-011 SHALL keep a WIDTH-bit phase counter that increments by 1 every clock and wraps from 2^WIDTH-1 to 0.
REQ-012 SHALL generate period_tick in each clock where phase = 2^WIDTH-1, so that every value update takes effect at the start of a new PWM period.
REQ-013 SHALL keep a divider counting period_ticks from 0 to PERIODS_PER_STEP-1 and wrapping; step_tick = period_tick AND divider = PERIODS_PER_STEP-1.
REQ-014 SHALL implement the states IDLE, UP and DOWN.
REQ-015 On load: target_reg <= target and divider <= 0; the phase counter SHALL NOT be affected.
REQ-016 On load, the next state SHALL be UP if target > value, DOWN if target < value, and IDLE if they are equal (no done pulse in the equal case).
REQ-017 On step_tick in UP: if target_reg - value <= STEP, then value <= target_reg, state <= IDLE and done <= 1; otherwise value <= value + STEP.
REQ-018 On step_tick in DOWN: if value - target_reg <= STEP, then value <= target_reg, state <= IDLE and done <= 1; otherwise value <= value - STEP.
REQ-019 SHALL ensure value never overflows or underflows; clamping to target_reg (REQ-017/018) guarantees this.
REQ-020 In IDLE, step_tick SHALL have no effect and value SHALL hold.
REQ-021 load and step_tick in the same cycle: load SHALL win and no step is taken that cycle.
REQ-022 load during UP or DOWN SHALL retarget from the current value; direction is re-evaluated per REQ-016, and no done is issued for the abandoned target.
REQ-023 done SHALL be registered and high for exactly one clock, namely the first clock in which the new value = target_reg; otherwise done = 0.
REQ-024 busy SHALL be a combinational decode of the state: 1 in UP or DOWN, 0 in IDLE.

Reset
REQ-025 While reset_n = 0, regardless of clock: value = 0, target_reg = 0, phase = 0, divider = 0, state = IDLE, done = 0, busy = 0.
REQ-026 Reset asserted mid-ramp SHALL abort the ramp immediately with no done pulse; after release, the block SHALL remain IDLE until the next load.

Verification (WIDTH=4 unless stated)
REQ-027 PERIODS_PER_STEP=1, STEP=1; after reset, load target=3 -> value goes 1, 2, 3 at successive phase wraps (16 clocks apart); done is high for one clock alongside value=3; busy then falls.
REQ-028 From value=3, load target=0 -> value goes 2, 1, 0 at 16-clock spacing; state is DOWN throughout; done pulses once at 0.
REQ-029 STEP=4, PERIODS_PER_STEP=2; load target=10 from 0 -> value goes 4, 8, 10 at 32-clock spacing; the last step clamps to 10 with no overshoot.
REQ-030 Load target=12 at value=5 while ramping up, then load target=2 -> direction flips to DOWN with no done pulse; value ramps 4, 3, 2 and done pulses once.
REQ-031 Load target equal to value -> busy stays 0 and done stays 0; load coinciding with step_tick -> value unchanged that cycle.
REQ-032 reset_n pulsed low mid-ramp, asynchronously to clock -> value = 0 and busy = 0 immediately; no done pulse; the block stays IDLE after release.
